rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 register file among N_REQ writeback requesters (e.g. ALU, LSU, CSR/debug).
- Uses a valid/ready handshake per requester and round-robin arbitration.
- Drives the register file's write port from registered outputs.
- Keeps a busy scoreboard of destinations reserved at issue but not yet written, so decode can stall on RAW hazards.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*AW  destination register; requester i occupies bits [i*AW +: AW].
- req_data  in  N_REQ*XLEN  write data; requester i occupies bits [i*XLEN +: XLEN].
- req_ready  out  N_REQ  one-hot or zero grant, combinational.
- rsv_valid  in  1  issue stage reserves a destination.
- rsv_addr  in  AW  destination being reserved.
- chk_addr1  in  AW  hazard query address 1.
- chk_addr2  in  AW  hazard query address 2.
- busy1  out  1  chk_addr1 is pending, combinational.
- busy2  out  1  chk_addr2 is pending, combinational.
- rf_reg_wr  out  1  register file write enable, registered.
- rf_waddr  out  AW  register file write address, registered.
- rf_wdata  out  XLEN  register file write data, registered.

Behaviour:
- Reset (async, active-high):
  - rf_reg_wr=0, rf_waddr=0, rf_wdata=0.
  - All busy bits = 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has highest priority first.
  - Clear-pending register = 0.
- Reset asserted mid-operation discards any in-flight grant. No write is issued after reset deasserts unless a new request arrives.
- Arbitration:
  - Search starts at pointer+1, modulo N_REQ. The first requester with req_valid set is granted.
  - At most one req_ready is high per cycle.
  - When no request is valid, req_ready=0 and the pointer is held.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i] at a posedge. The pointer updates to i on that edge.
  - Requester rules: once req_valid is raised, it must not drop, and addr/data must not change, until accepted.
  - req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- Write issue latency, for a transfer at the posedge ending cycle k:
  - During cycle k+1: rf_reg_wr=1, rf_waddr=addr, rf_wdata=data.
  - The register file captures the write on the negedge within cycle k+1.
  - With no transfer, rf_reg_wr=0 on the next cycle; waddr/wdata hold their previous values.
- x0 handling:
  - A transfer to address 0 is accepted (ready asserted normally), but rf_reg_wr stays 0.
  - rsv to address 0 never sets a busy bit.
  - busy for query address 0 is always 0.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the posedge.
  - A transfer to addr A records A in the clear-pending register.
  - busy[A] clears at the posedge ending cycle k+1, after the register file write has landed. The cleared bit is visible from cycle k+2.
  - busyN = busy[chk_addrN]. No forwarding.
- Simultaneous events:
  - Set and clear of the same address on the same edge: set wins, bit stays 1.
  - A new reservation of an address already busy keeps it busy. Bits are single, not counted, and the first completing write clears them.
  - The issue stage must not reserve an address that already has an outstanding reservation.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 grants.

Decomposition:
- Package rf_pkg holds XLEN, AW, NREGS=32, and typedefs rf_addr_t (logic [AW-1:0]) and rf_data_t (logic [XLEN-1:0]).
- One sub-module, rr_arbiter (N_REQ): valid vector and pointer in, one-hot grant and encoded index out, purely combinational.
- The pointer register lives in rf_wb_scheduler.

Test Plan:
- Reset: assert reset mid-write with req_valid[1]=1 -> all outputs 0 immediately, busy1=busy2=0. After release, requester 0 is the first winner when all requesters are valid.
- Single write: rsv x5. Next cycle req0 {x5, 0xDEADBEEF}. Then:
  - req_ready[0]=1 in the same cycle.
  - rf_reg_wr=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle later.
  - busy1 (chk_addr1=5) stays 1 through that cycle and reads 0 one cycle after.
- Round-robin: all 3 valid for 6 cycles with addrs x1/x2/x3 -> grant order 0,1,2,0,1,2. Each req_valid holds until accepted.
- x0: rsv x0 and req2 {x0, 0x1234} -> busy for 0 stays 0, req_ready[2]=1, rf_reg_wr stays 0.
- Collision: busy[7] is clearing from a write while rsv x7 arrives on the same edge -> busy[7] remains 1.
- Backpressure: req1 valid while req0 is granted every cycle with pointer at 0 -> req1 is granted on the next cycle. req1's addr/data are unchanged and written correctly.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback path.
package rf_pkg;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef logic [AW-1:0]   rf_addr_t;
    typedef logic [XLEN-1:0] rf_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins just after the last winner.
module rr_arbiter #(
    parameter int N_REQ = 3,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PW-1:0]    idx_o,
    output logic             any_o
);

    logic [PW-1:0] candIdx;

    // Walk from ptr+1 around to ptr; the first valid requester found wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        candIdx = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            candIdx = PW'((int'(ptr_i) + off) % N_REQ);
            if (!any_o && valid_i[candIdx]) begin
                any_o            = 1'b1;
                grant_o[candIdx] = 1'b1;
                idx_o            = candIdx;
            end
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the register file write port among writeback requesters and
// tracks destinations that were reserved at issue but not yet written.
module rf_wb_scheduler
    import rf_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*XLEN-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  rsv_valid,
    input  logic [AW-1:0]         rsv_addr,
    input  logic [AW-1:0]         chk_addr1,
    input  logic [AW-1:0]         chk_addr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_reg_wr,
    output logic [AW-1:0]         rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gntIdx;
    logic [N_REQ-1:0] grant;
    logic             gntAny;
    logic             xfer;
    rf_addr_t         xferAddr;
    rf_data_t         xferData;

    logic             wr_q, wr_d;
    rf_addr_t         waddr_q, waddr_d;
    rf_data_t         wdata_q, wdata_d;
    logic             clrValid_q, clrValid_d;
    rf_addr_t         clrAddr_q, clrAddr_d;
    logic [NREGS-1:0] busy_q, busy_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gntIdx),
        .any_o   (gntAny)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    assign req_ready = reset ? '0 : grant;
    assign xfer      = gntAny && !reset;
    assign xferAddr  = req_addr[int'(gntIdx)*AW +: AW];
    assign xferData  = req_data[int'(gntIdx)*XLEN +: XLEN];

    // A write clears its busy bit one edge after issue, once the register file
    // has captured it; a reservation on that same edge takes precedence.
    always_comb begin
        ptr_d      = xfer ? gntIdx : ptr_q;
        wr_d       = xfer && (xferAddr != '0);
        waddr_d    = xfer ? xferAddr : waddr_q;
        wdata_d    = xfer ? xferData : wdata_q;
        clrValid_d = xfer;
        clrAddr_d  = xfer ? xferAddr : clrAddr_q;
        busy_d     = busy_q;
        if (clrValid_q) begin
            busy_d[clrAddr_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= PW'(N_REQ - 1);
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            clrValid_q <= 1'b0;
            clrAddr_q  <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            clrValid_q <= clrValid_d;
            clrAddr_q  <= clrAddr_d;
            busy_q     <= busy_d;
        end
    end

    assign busy1     = (chk_addr1 != '0) && busy_q[chk_addr1];
    assign busy2     = (chk_addr2 != '0) && busy_q[chk_addr2];
    assign rf_reg_wr = wr_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;

endmodule
